// File: rtl/uart_pkg.sv
// Shared UART definitions: byte type and receiver state encodings.
package uart_pkg;

  typedef logic [7:0] uart_byte_t;

  typedef enum logic [2:0] {
    RX_IDLE    = 3'd0,
    RX_START   = 3'd1,
    RX_DATA    = 3'd2,
    RX_STOP    = 3'd3,
    RX_CLEANUP = 3'd4
  } uart_rx_state_e;

endpackage : uart_pkg

// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT byte FIFO behind the UART receiver. The receiver is never
// stalled: a byte arriving while full (with no pop in the same cycle) is dropped,
// a sticky overflow flag is raised and a saturating drop counter advances.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  input  uart_byte_t      in_byte,
  output logic            out_valid,
  output uart_byte_t      out_byte,
  input  logic            out_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic            full,
  output logic            overflow,
  input  logic            overflow_clear,
  output logic [7:0]      drop_count
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [AW:0]   COUNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   COUNT_ZERO = (AW+1)'(0);
  localparam logic [AW:0]   COUNT_FULL = (AW+1)'(DEPTH);

  // Reject a DEPTH the natural pointer wrap cannot support.
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
    $error("uart_rx_fifo: DEPTH must be a power of 2 and >= 2");
  end

  uart_byte_t    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    drop_count_q, drop_count_d;

  logic full_s;
  logic valid_s;
  logic pop_s;
  logic push_s;
  logic drop_s;

  // Status decoded from the occupancy register only.
  assign full_s  = (count_q == COUNT_FULL);
  assign valid_s = (count_q != COUNT_ZERO);

  // A pop frees a slot in the same cycle, so push while full is legal when popping.
  assign pop_s  = valid_s && out_ready;
  assign push_s = in_valid && (!full_s || pop_s);
  assign drop_s = in_valid && full_s && !pop_s;

  // Next-state for pointers, occupancy and overflow bookkeeping.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + COUNT_ONE;
      2'b01:   count_d = count_q - COUNT_ONE;
      default: count_d = count_q;
    endcase

    // A drop outranks a coincident clear: the new drop is the first one counted.
    if (drop_s) begin
      overflow_d = 1'b1;
      if (overflow_clear) begin
        drop_count_d = 8'd1;
      end else if (drop_count_q == 8'hFF) begin
        drop_count_d = 8'hFF;
      end else begin
        drop_count_d = drop_count_q + 8'd1;
      end
    end else if (overflow_clear) begin
      overflow_d   = 1'b0;
      drop_count_d = 8'd0;
    end else begin
      overflow_d   = overflow_q;
      drop_count_d = drop_count_q;
    end
  end

  // Control state registers with synchronous reset; stored bytes are left as-is.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= COUNT_ZERO;
      overflow_q   <= 1'b0;
      drop_count_q <= 8'd0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  // Byte storage write port; a strobe coincident with reset is ignored.
  always_ff @(posedge clock) begin
    if (push_s && !reset) begin
      mem_q[wr_ptr_q] <= in_byte;
    end
  end

  assign out_byte   = mem_q[rd_ptr_q];
  assign out_valid  = valid_s;
  assign full       = full_s;
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed steps plus random traffic,
// compared against a queue-based reference model of the FIFO rules.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;

  logic       clock;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_byte;
  logic       out_valid;
  logic [7:0] out_byte;
  logic       out_ready;
  logic [4:0] count;
  logic       full;
  logic       overflow;
  logic       overflow_clear;
  logic [7:0] drop_count;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [7:0] mq[$];
  logic       m_ovf = 1'b0;
  int         m_dc  = 0;

  uart_rx_fifo #(.DEPTH(DEPTH)) dut (
    .clock          (clock),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_byte        (in_byte),
    .out_valid      (out_valid),
    .out_byte       (out_byte),
    .out_ready      (out_ready),
    .count          (count),
    .full           (full),
    .overflow       (overflow),
    .overflow_clear (overflow_clear),
    .drop_count     (drop_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    chk("count", 32'(count), 32'(mq.size()));
    chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    chk("full", 32'(full), 32'(mq.size() == DEPTH));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("drop_count", 32'(drop_count), 32'(m_dc));
    if (mq.size() > 0) chk("out_byte", 32'(out_byte), 32'(mq[0]));
  endtask

  // One clock cycle: drive inputs, check head at handshake, advance model, check.
  task automatic step(input logic v, input logic [7:0] b, input logic rdy,
                      input logic clr, input logic rst);
    bit m_full;
    bit m_pop;
    in_valid       = v;
    in_byte        = b;
    out_ready      = rdy;
    overflow_clear = clr;
    reset          = rst;
    #1;
    if (!rst && rdy && mq.size() > 0) chk("head_at_pop", 32'(out_byte), 32'(mq[0]));
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0;
      m_dc  = 0;
    end else begin
      m_full = (mq.size() == DEPTH);
      m_pop  = rdy && (mq.size() > 0);
      if (v && m_full && !m_pop) begin
        m_ovf = 1'b1;
        if (clr) m_dc = 1;
        else if (m_dc < 255) m_dc = m_dc + 1;
      end else begin
        if (clr) begin
          m_ovf = 1'b0;
          m_dc  = 0;
        end
        if (m_pop) void'(mq.pop_front());
        if (v) mq.push_back(b);
      end
    end
    @(posedge clock);
    #1;
    check_state();
  endtask

  initial begin
    in_valid = 1'b0; in_byte = 8'h00; out_ready = 1'b0;
    overflow_clear = 1'b0; reset = 1'b1;

    // Reset
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);

    // Three bytes, then drain back-to-back
    step(1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
    chk("first_visible", 32'(out_byte), 32'h41);
    step(1'b1, 8'h42, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h43, 1'b0, 1'b0, 1'b0);
    chk("three_count", 32'(count), 32'd3);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("drained_valid", 32'(out_valid), 32'd0);

    // Fill, overrun by two, drain
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hBB, 1'b0, 1'b0, 1'b0);
    chk("overrun_full", 32'(full), 32'd1);
    chk("overrun_dc", 32'(drop_count), 32'd2);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Full: push and pop same cycle
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    chk("pushpop_count", 32'(count), 32'd16);
    chk("pushpop_dc", 32'(drop_count), 32'd2);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Saturating drop counter and clear behaviour
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    chk("sat_dc", 32'(drop_count), 32'd255);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("clear_ovf", 32'(overflow), 32'd0);
    chk("clear_dc", 32'(drop_count), 32'd0);
    step(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
    chk("clear_drop_ovf", 32'(overflow), 32'd1);
    chk("clear_drop_dc", 32'(drop_count), 32'd1);

    // Reset mid-operation with a coincident strobe
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b0, 1'b0, 1'b1);
    chk("midreset_count", 32'(count), 32'd0);
    chk("midreset_valid", 32'(out_valid), 32'd0);
    step(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
    chk("after_reset_head", 32'(out_byte), 32'h99);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Pointer wrap with random consumer readiness
    for (int k = 0; k < 40; k++) step(1'b1, 8'(k + 1), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("wrap_empty", 32'(out_valid), 32'd0);

    // Random traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 15) == 0), 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_uart_rx_fifo

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer placed directly downstream of the UART receiver. It captures each one-cycle `data_valid` / `data_byte` strobe into a first-word-fall-through FIFO and presents bytes to the consumer (command decoder) on a valid/ready handshake. Overruns never stall the receiver: excess bytes are dropped, a sticky flag is raised and a saturating drop counter is incremented.

## Interface
- `DEPTH`, default 16: number of byte entries. Must be a power of 2 and ≥ 2.
- `AW`: derived localparam, `$clog2(DEPTH)`. It is not a port-level parameter.

Ports:
- `clock`  in  1  system clock.
- `reset`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  one-cycle byte strobe from the receiver's `data_valid`.
- `in_byte`  in  8  byte from the receiver's `data_byte`; sampled only when `in_valid` is high.
- `out_valid`  out  1  head entry present; equals "not empty".
- `out_byte`  out  8  head entry; defined only while `out_valid` is high.
- `out_ready`  in  1  consumer accepts the head this cycle.
- `count`  out  AW+1  current occupancy, 0..DEPTH.
- `full`  out  1  `count == DEPTH`.
- `overflow`  out  1  sticky; set when a byte is dropped.
- `overflow_clear`  in  1  clears `overflow` and `drop_count`.
- `drop_count`  out  8  number of dropped bytes, saturating at 255.

## Operation
- Storage is a register array of DEPTH × 8 bits, with write pointer `wr_ptr` and read pointer `rd_ptr`, both AW bits wide and wrapping naturally.
- `count` is an explicit AW+1-bit register; `full` and `out_valid` are derived from it.
- Pop: when `out_valid && out_ready`, `rd_ptr` increments.
- Push: when `in_valid` and either (`count < DEPTH`) or (pop this cycle), write `in_byte` to `mem[wr_ptr]` and increment `wr_ptr`.
  - Push and pop in the same cycle while full is legal: there is no drop and `count` is unchanged.
- Drop: when `in_valid`, `count == DEPTH` and there is no pop:
  - the byte is discarded;
  - `overflow` is set to 1;
  - `drop_count` increments, holding at 255.
- Count update: +1 on push only, −1 on pop only, unchanged on both or neither.
- Empty case: `out_valid` is 0, so no pop can occur. There is no bypass; a push into an empty FIFO appears at the head on the following cycle.
- `out_byte` is a combinational read of `mem[rd_ptr]`.
- `overflow_clear` and a drop in the same cycle: the drop wins. `overflow` ends at 1 and `drop_count` ends at 1.
- Reset:
  - `wr_ptr`, `rd_ptr` and `count` return to 0;
  - `overflow` returns to 0 and `drop_count` to 0;
  - `out_valid` is 0 and `full` is 0;
  - `mem` contents are not reset.
- Reset mid-operation discards all buffered bytes. An `in_valid` asserted in the same cycle as `reset` is ignored.

## Timing
- Push to visibility: a byte pushed in cycle N has `out_valid` and `out_byte` valid in cycle N+1.
- `count`, `full`, `overflow` and `drop_count` are all registered and reflect cycle-N events in cycle N+1.
- Pop: the head advances one cycle after the handshake. With back-to-back ready, one byte is delivered per cycle.
- The receiver strobes at most once per ~10×CLKS_PER_BIT cycles; the FIFO still accepts a push on every cycle.
- Output combinational paths:
  - `out_byte` depends on `rd_ptr` and `mem` only;
  - `out_valid` and `full` are decoded from the `count` register;
  - no input reaches any output combinationally.

## Structure
- Shared package `uart_pkg` holds `typedef logic [7:0] uart_byte_t` and the receiver state encodings (IDLE/START/DATA/STOP/CLEANUP as a 3-bit enum). This block uses `uart_byte_t` for `in_byte`, `out_byte` and `mem`.
- No sub-module. Storage, pointers and flag logic fit in one module.
- Assertion: `DEPTH` is a power of 2 and ≥ 2; check at elaboration.

## Test plan
- Reset, then push 0x41, 0x42, 0x43 with `out_ready` = 0 → `count` = 3, `out_byte` = 0x41. Raise `out_ready` → 0x41, 0x42, 0x43 on consecutive cycles, then `out_valid` = 0 and `count` = 0.
- Push 16 bytes 0x00..0x0F, then push 0xAA and 0xBB with no pop → `full` = 1, `overflow` = 1, `drop_count` = 2. Draining yields 0x00..0x0F only.
- With the FIFO full, push 0x55 while popping in the same cycle → no drop, `count` stays 16, and 0x55 is the last byte drained.
- Force 300 drops → `drop_count` = 255. Pulse `overflow_clear` → next cycle `overflow` = 0 and `drop_count` = 0. Clear coincident with a drop → `overflow` = 1, `drop_count` = 1.
- Fill 7 bytes, assert `reset` for one cycle alongside `in_valid` = 1 → next cycle `count` = 0 and `out_valid` = 0. A subsequent push of 0x99 is the head one cycle later.
- Pointer wrap: 40 push/pop pairs of incrementing bytes with random `out_ready` → output order is exact, and `count` never exceeds 16 or goes below 0.
